// File: rtl/wb_pkg.sv
// Shared widths, scoreboard counter type and the FIFO entry layout for the write-back stage.
package wb_pkg;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int Q_DEPTH = 2;
  localparam int CNT_W   = 2;
  localparam int NREG    = 2 ** ADDR_W;

  typedef logic [CNT_W-1:0] pend_cnt_t;
  localparam pend_cnt_t CNT_MAX = '1;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_writeback_if.sv
// Write-back stage bus: issue/scoreboard, ALU and load inputs, register-file write port, ID bypass.
interface reg_writeback_if;
  import wb_pkg::*;

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_RDaddr;
  logic              issue_stall;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_RDaddr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_RDaddr;
  logic [DATA_W-1:0] mem_data;
  logic              RegWrite;
  logic [ADDR_W-1:0] RDaddr;
  logic [DATA_W-1:0] src1;
  logic [ADDR_W-1:0] RSaddr;
  logic [ADDR_W-1:0] RTaddr;
  logic              RSbusy;
  logic              RTbusy;
  logic              RSfwd;
  logic              RTfwd;
  logic [DATA_W-1:0] fwd_data;

  modport slave (
    input  issue_valid, issue_RDaddr, alu_valid, alu_RDaddr, alu_data,
           mem_valid, mem_RDaddr, mem_data, RSaddr, RTaddr,
    output issue_stall, mem_ready, RegWrite, RDaddr, src1,
           RSbusy, RTbusy, RSfwd, RTfwd, fwd_data
  );

  modport master (
    output issue_valid, issue_RDaddr, alu_valid, alu_RDaddr, alu_data,
           mem_valid, mem_RDaddr, mem_data, RSaddr, RTaddr,
    input  issue_stall, mem_ready, RegWrite, RDaddr, src1,
           RSbusy, RTbusy, RSfwd, RTfwd, fwd_data
  );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries; head visible combinationally, push/pop take effect on posedge.
// Pushes while full are ignored; the caller gates push with !o_full and pop with !o_empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = Q_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  wb_entry_t i_push_dat,
  input  logic      i_pop,
  output wb_entry_t o_pop_dat,
  output logic      o_full,
  output logic      o_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0] r_wptr;
  logic [PW:0] r_rptr;
  wb_entry_t   r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign o_pop_dat = r_mem[r_rptr[PW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[PW-1:0]] <= i_push_dat;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_do_pop) r_rptr <= r_rptr + 1'b1;
    end
  end
endmodule

// File: rtl/reg_writeback.sv
// Write-back merge of ALU (1 cycle) and queued loads (>=2 cycles) onto one registered write port.
// ALU always accepted; loads back-pressured by mem_ready when the queue is full. Scoreboard + bypass for ID.
module reg_writeback
  import wb_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  reg_writeback_if.slave bus
);
  wb_entry_t       w_head;
  wb_entry_t       w_push_ent;
  wb_entry_t       w_wr_ent;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_head_zero;
  logic            w_alu_wr;
  logic            w_wr_en;
  logic [NREG-1:0] w_inc;
  logic [NREG-1:0] w_dec;

  logic              r_regwrite;
  logic [ADDR_W-1:0] r_rdaddr;
  logic [DATA_W-1:0] r_src1;
  pend_cnt_t         r_cnt [NREG];

  assign bus.mem_ready = rst_n && !w_full;
  assign w_push        = bus.mem_valid && bus.mem_ready;
  assign w_push_ent    = '{addr: bus.mem_RDaddr, data: bus.mem_data};

  wb_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_dat (w_push_ent),
    .i_pop      (w_pop),
    .o_pop_dat  (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign w_head_zero = !w_empty && (w_head.addr == ZERO_REG);
  assign w_alu_wr    = bus.alu_valid && (bus.alu_RDaddr != ZERO_REG);

  // r0 loads are discarded from the head without claiming the write port.
  always_comb begin
    w_pop    = w_head_zero;
    w_wr_en  = 1'b0;
    w_wr_ent = w_head;
    if (w_alu_wr) begin
      w_wr_en  = 1'b1;
      w_wr_ent = '{addr: bus.alu_RDaddr, data: bus.alu_data};
    end else if (!w_empty && !w_head_zero) begin
      w_pop   = 1'b1;
      w_wr_en = 1'b1;
    end
  end

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (bus.issue_valid && (bus.issue_RDaddr != ZERO_REG)) w_inc[bus.issue_RDaddr] = 1'b1;
    if (w_wr_en) w_dec[w_wr_ent.addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regwrite <= 1'b0;
      r_rdaddr   <= '0;
      r_src1     <= '0;
    end else begin
      r_regwrite <= w_wr_en;
      if (w_wr_en) begin
        r_rdaddr <= w_wr_ent.addr;
        r_src1   <= w_wr_ent.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (w_inc[r] && !w_dec[r] && (r_cnt[r] != CNT_MAX))
          r_cnt[r] <= pend_cnt_t'(r_cnt[r] + 1'b1);
        else if (w_dec[r] && !w_inc[r] && (r_cnt[r] != '0))
          r_cnt[r] <= pend_cnt_t'(r_cnt[r] - 1'b1);
      end
    end
  end

  assign bus.RegWrite    = r_regwrite;
  assign bus.RDaddr      = r_rdaddr;
  assign bus.src1        = r_src1;
  assign bus.fwd_data    = r_src1;
  assign bus.issue_stall = (r_cnt[bus.issue_RDaddr] == CNT_MAX);
  assign bus.RSbusy      = (r_cnt[bus.RSaddr] != '0);
  assign bus.RTbusy      = (r_cnt[bus.RTaddr] != '0);
  assign bus.RSfwd       = r_regwrite && (r_rdaddr == bus.RSaddr) && (bus.RSaddr != ZERO_REG);
  assign bus.RTfwd       = r_regwrite && (r_rdaddr == bus.RTaddr) && (bus.RTaddr != ZERO_REG);
endmodule
